// File: rtl/mmio_pkg.sv
// Shared bus and register-map definitions for memory-mapped I/O peripherals.
// Bus command encoding, timer register offsets and CTRL/STATUS bit positions.
package mmio_pkg;

   typedef enum logic [1:0] {
      M_NOP   = 2'b00,
      M_WRITE = 2'b01,
      M_READ  = 2'b10
   } mem_cmd_t;

   localparam logic [2:0] TMR_CTRL     = 3'd0;
   localparam logic [2:0] TMR_PERIOD   = 3'd1;
   localparam logic [2:0] TMR_COUNT    = 3'd2;
   localparam logic [2:0] TMR_STATUS   = 3'd3;
   localparam logic [2:0] TMR_PRESCALE = 3'd4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int STAT_MATCH   = 0;
   localparam int STAT_OVR     = 1;

   localparam logic [8:0] TMR_BASE_DEFAULT = 9'h100;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mmio_timer: counts enabled cycles and pulses tick when the
// count reaches limit, giving one tick every limit+1 enabled cycles.
module timer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] limit,
   output logic               tick
);

   localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

   logic [PRESC_W-1:0] pcnt;
   logic               at_limit;

   assign at_limit = en && (pcnt == limit);
   assign tick     = at_limit && !reset;

   // A limit lowered below the running count lets pcnt wrap before matching.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= at_limit ? '0 : pcnt + ONE;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 16-bit timer: prescaled up-counter, period match, sticky status
// and level irq. Define MMIO_TIMER_ONESHOT_EN to make CTRL.ONESHOT writable.
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [8:0] BASE_ADDR = TMR_BASE_DEFAULT,
   parameter int         PRESC_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         mem_cmd,
   input  logic [8:0]         mem_addr,
   input  logic [15:0]        din,
   inout  tri logic [15:0]    mem_data,
   output logic               irq,
   output logic               tick
);

   logic               hit, wr_en, rd_en;
   logic [2:0]         off;
   logic               wr_ctrl, wr_period, wr_count, wr_status, wr_prescale;
   logic               en, irq_en, oneshot;
   logic [15:0]        period, count;
   logic               match, ovr;
   logic [PRESC_W-1:0] prescale;
   logic               adv, match_set;
   logic [15:0]        rdata;

   assign hit         = (mem_addr[8:3] == BASE_ADDR[8:3]);
   assign off         = mem_addr[2:0];
   assign wr_en       = hit && (mem_cmd == M_WRITE);
   assign rd_en       = hit && (mem_cmd == M_READ);
   assign wr_ctrl     = wr_en && (off == TMR_CTRL);
   assign wr_period   = wr_en && (off == TMR_PERIOD);
   assign wr_count    = wr_en && (off == TMR_COUNT);
   assign wr_status   = wr_en && (off == TMR_STATUS);
   assign wr_prescale = wr_en && (off == TMR_PRESCALE);

   timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (wr_count),
      .limit (prescale),
      .tick  (adv)
   );

   // The compare uses the PERIOD value held before any same-cycle write.
   assign match_set = adv && (count == period);
   assign tick      = adv;

   always_ff @(posedge clk) begin
      if (reset) begin
         en       <= 1'b0;
         irq_en   <= 1'b0;
         period   <= 16'hFFFF;
         count    <= 16'h0000;
         match    <= 1'b0;
         ovr      <= 1'b0;
         prescale <= '0;
      end else begin
         if (wr_ctrl) begin
            en     <= din[CTRL_EN];
            irq_en <= din[CTRL_IRQ_EN];
         end
         // NOTE: with non-blocking assignments the last one in program order wins,
         // so the one-shot disable below overrides a same-cycle CTRL write.
         if (match_set && oneshot) en <= 1'b0;
         if (wr_period)   period   <= din;
         if (wr_prescale) prescale <= din[PRESC_W-1:0];
         if (wr_count) begin
            count <= 16'h0000;
         end else if (adv) begin
            count <= (count == period) ? 16'h0000 : count + 16'd1;
         end
         // Setting beats write-1-to-clear when both land on the same edge.
         match <= match_set | (match & ~(wr_status & din[STAT_MATCH]));
         ovr   <= (match_set & match) | (ovr & ~(wr_status & din[STAT_OVR]));
      end
   end

`ifdef MMIO_TIMER_ONESHOT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         oneshot <= 1'b0;
      end else if (wr_ctrl) begin
         oneshot <= din[CTRL_ONESHOT];
      end
   end
`else
   assign oneshot = 1'b0;
`endif

   // NOTE: rdata gets a full default before the case so no latch is inferred.
   always_comb begin
      rdata = 16'h0000;
      case (off)
         TMR_CTRL: begin
            rdata[CTRL_EN]      = en;
            rdata[CTRL_IRQ_EN]  = irq_en;
            rdata[CTRL_ONESHOT] = oneshot;
         end
         TMR_PERIOD: rdata = period;
         TMR_COUNT:  rdata = count;
         TMR_STATUS: begin
            rdata[STAT_MATCH] = match;
            rdata[STAT_OVR]   = ovr;
         end
         TMR_PRESCALE: rdata[PRESC_W-1:0] = prescale;
         default: ;
      endcase
   end

   assign mem_data = rd_en ? rdata : 16'bz;
   assign irq      = !reset && match && irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: reset readback table, directed corner
// sequences and a randomized bus run against a cycle-level reference model.
module tb_mmio_timer;

   localparam logic [8:0] BASE = 9'h100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_cmd = 2'b00;
   logic [8:0]  mem_addr = 9'h000;
   logic [15:0] din = 16'h0000;
   wire  [15:0] mem_data;
   logic        irq, tick;
   logic        keep = 1'b0;

   // Holds the bus at zero whenever the timer is expected to stay off it.
   assign mem_data = keep ? 16'h0000 : 16'bz;

   int n_vec  = 0;
   int n_miss = 0;

   mmio_timer dut (
      .clk      (clk),
      .reset    (reset),
      .mem_cmd  (mem_cmd),
      .mem_addr (mem_addr),
      .din      (din),
      .mem_data (mem_data),
      .irq      (irq),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  addr;
      logic [15:0] exp;
   } rd_vec_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [8:0] a, input logic [15:0] d);
      mem_cmd  = 2'b01;
      mem_addr = a;
      din      = d;
      cyc();
      mem_cmd  = 2'b00;
   endtask

   task automatic rd(input logic [8:0] a, output logic [15:0] v);
      mem_cmd  = 2'b10;
      mem_addr = a;
      #1;
      v        = mem_data;
      mem_cmd  = 2'b00;
   endtask

   task automatic chk_rd(input string name, input logic [8:0] a, input logic [15:0] exp);
      logic [15:0] v;
      rd(a, v);
      check(name, v, exp);
   endtask

   // Reference model state: plain integers and flags.
   bit m_en, m_irqen, m_os, m_match, m_ovr;
   int m_period, m_count, m_presc, m_pcnt;

   task automatic model_reset();
      m_en = 0; m_irqen = 0; m_os = 0; m_match = 0; m_ovr = 0;
      m_period = 65535; m_count = 0; m_presc = 0; m_pcnt = 0;
   endtask

   function automatic logic [15:0] model_read(input int off);
      case (off)
         0:       return {13'd0, m_os, m_irqen, m_en};
         1:       return 16'(m_period);
         2:       return 16'(m_count);
         3:       return {14'd0, m_ovr, m_match};
         4:       return 16'(m_presc);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_step(input bit w, input bit h, input int off, input logic [15:0] d);
      bit t, ms, old_match, old_os;
      t         = m_en && (m_pcnt == m_presc);
      ms        = t && (m_count == m_period);
      old_match = m_match;
      old_os    = m_os;
      m_match   = ms || (m_match && !(w && h && off == 3 && d[0]));
      m_ovr     = (ms && old_match) || (m_ovr && !(w && h && off == 3 && d[1]));
      if (t) m_count = (m_count == m_period) ? 0 : (m_count + 1) % 65536;
      if (m_en) m_pcnt = t ? 0 : (m_pcnt + 1) % 256;
      if (w && h) begin
         case (off)
            0: begin
               m_en    = d[0];
               m_irqen = d[1];
`ifdef MMIO_TIMER_ONESHOT_EN
               m_os    = d[2];
`endif
            end
            1: m_period = int'(d);
            2: begin m_count = 0; m_pcnt = 0; end
            4: m_presc = int'(d[7:0]);
            default: ;
         endcase
      end
      if (ms && old_os) m_en = 0;
   endtask

   initial begin
      rd_vec_t     reset_tbl[8];
      int          exp_cnt[8];
      int          ticks;
      logic [15:0] v;

      reset_tbl[0] = '{BASE + 9'd0, 16'h0000};
      reset_tbl[1] = '{BASE + 9'd1, 16'hFFFF};
      reset_tbl[2] = '{BASE + 9'd2, 16'h0000};
      reset_tbl[3] = '{BASE + 9'd3, 16'h0000};
      reset_tbl[4] = '{BASE + 9'd4, 16'h0000};
      reset_tbl[5] = '{BASE + 9'd5, 16'h0000};
      reset_tbl[6] = '{BASE + 9'd6, 16'h0000};
      reset_tbl[7] = '{BASE + 9'd7, 16'h0000};
      exp_cnt = '{1, 2, 3, 0, 1, 2, 3, 0};

      // Reset and register readback
      cyc(); cyc();
      check("irq_in_reset", 16'(irq), 16'h0);
      check("tick_in_reset", 16'(tick), 16'h0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_rd($sformatf("reset_rd_off%0d", i), reset_tbl[i].addr, reset_tbl[i].exp);
         cyc();
      end
      keep = 1'b1;
      chk_rd("no_drive_read_0FF", 9'h0FF, 16'h0000);
      chk_rd("no_drive_read_0F9", 9'h0F9, 16'h0000);
      mem_cmd = 2'b00; mem_addr = BASE + 9'd1; #1;
      check("no_drive_nop", mem_data, 16'h0000);
      mem_cmd = 2'b11; #1;
      check("no_drive_cmd11", mem_data, 16'h0000);
      mem_cmd = 2'b00;
      keep = 1'b0;
      cyc();

      // Period 3, prescale 0: count 1,2,3,0 with match then overrun
      wr(BASE + 9'd1, 16'd3);
      wr(BASE + 9'd4, 16'd0);
      wr(BASE + 9'd0, 16'h0003);
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk_rd($sformatf("p3_count_%0d", i), BASE + 9'd2, 16'(exp_cnt[i]));
         if (i == 2) check("p3_irq_before_match", 16'(irq), 16'h0);
         if (i == 3) begin
            chk_rd("p3_status_first", BASE + 9'd3, 16'h0001);
            check("p3_irq_first", 16'(irq), 16'h1);
         end
         if (i == 7) chk_rd("p3_status_ovr", BASE + 9'd3, 16'h0003);
      end
      wr(BASE + 9'd0, 16'h0000);
      check("disabled_tick", 16'(tick), 16'h0);
      cyc(); cyc(); cyc();
      chk_rd("disabled_count_frozen", BASE + 9'd2, 16'd1);
      wr(BASE + 9'd3, 16'h0003);
      chk_rd("status_cleared", BASE + 9'd3, 16'h0000);
      check("irq_cleared", 16'(irq), 16'h0);

      // Prescale 4: one tick per 5 cycles
      wr(BASE + 9'd4, 16'd4);
      wr(BASE + 9'd1, 16'hFFFF);
      wr(BASE + 9'd2, 16'h0000);
      wr(BASE + 9'd0, 16'h0001);
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         ticks += int'(tick);
         cyc();
      end
      check("presc_tick_count", 16'(ticks), 16'd10);
      chk_rd("presc_count", BASE + 9'd2, 16'd10);
      wr(BASE + 9'd0, 16'h0000);

      // Match coinciding with STATUS write-1-to-clear
      wr(BASE + 9'd4, 16'd0);
      wr(BASE + 9'd1, 16'd2);
      wr(BASE + 9'd2, 16'h0000);
      wr(BASE + 9'd3, 16'h0003);
      wr(BASE + 9'd0, 16'h0003);
      cyc(); cyc(); cyc();
      chk_rd("w1c_first_match", BASE + 9'd3, 16'h0001);
      cyc(); cyc();
      wr(BASE + 9'd3, 16'h0001);
      chk_rd("w1c_set_wins", BASE + 9'd3, 16'h0003);
      check("w1c_irq_held", 16'(irq), 16'h1);
      wr(BASE + 9'd3, 16'h0001);
      chk_rd("w1c_clears", BASE + 9'd3, 16'h0002);
      check("w1c_irq_drops", 16'(irq), 16'h0);
      wr(BASE + 9'd0, 16'h0000);
      wr(BASE + 9'd3, 16'h0002);

      // COUNT above a new PERIOD wraps through FFFF before matching
      wr(BASE + 9'd1, 16'hFFFF);
      wr(BASE + 9'd2, 16'h0000);
      wr(BASE + 9'd0, 16'h0001);
      repeat (6) cyc();
      wr(BASE + 9'd0, 16'h0000);
      chk_rd("wrap_start_count", BASE + 9'd2, 16'd7);
      wr(BASE + 9'd1, 16'd5);
      wr(BASE + 9'd0, 16'h0001);
      repeat (65529) cyc();
      chk_rd("wrap_count_zero", BASE + 9'd2, 16'd0);
      chk_rd("wrap_no_match", BASE + 9'd3, 16'h0000);
      repeat (5) cyc();
      chk_rd("wrap_count_five", BASE + 9'd2, 16'd5);
      cyc();
      chk_rd("wrap_match_count", BASE + 9'd2, 16'd0);
      chk_rd("wrap_match_status", BASE + 9'd3, 16'h0001);
      cyc(); cyc(); cyc();
      check("cnt_wr_tick_live", 16'(tick), 16'h1);
      wr(BASE + 9'd2, 16'h1234);
      chk_rd("cnt_wr_beats_tick", BASE + 9'd2, 16'd0);

      // Reset mid-count with irq asserted
      wr(BASE + 9'd0, 16'h0003);
      check("irq_before_reset", 16'(irq), 16'h1);
      reset = 1'b1; #1;
      check("irq_mid_reset", 16'(irq), 16'h0);
      check("tick_mid_reset", 16'(tick), 16'h0);
      cyc();
      reset = 1'b0;
      chk_rd("post_reset_ctrl", BASE + 9'd0, 16'h0000);
      chk_rd("post_reset_count", BASE + 9'd2, 16'h0000);
      chk_rd("post_reset_status", BASE + 9'd3, 16'h0000);
      chk_rd("post_reset_period", BASE + 9'd1, 16'hFFFF);
      cyc();

      // One-shot versus periodic behaviour
      wr(BASE + 9'd1, 16'd2);
      wr(BASE + 9'd0, 16'h0005);
`ifdef MMIO_TIMER_ONESHOT_EN
      chk_rd("os_ctrl_rb", BASE + 9'd0, 16'h0005);
`else
      chk_rd("os_ctrl_rb", BASE + 9'd0, 16'h0001);
`endif
      cyc(); cyc(); cyc();
      cyc(); cyc(); cyc();
`ifdef MMIO_TIMER_ONESHOT_EN
      chk_rd("os_ctrl_after", BASE + 9'd0, 16'h0004);
      chk_rd("os_count_held", BASE + 9'd2, 16'd0);
      chk_rd("os_single_match", BASE + 9'd3, 16'h0001);
`else
      chk_rd("periodic_count", BASE + 9'd2, 16'd0);
      chk_rd("periodic_two_matches", BASE + 9'd3, 16'h0003);
`endif

      // Randomized bus traffic against the reference model
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         int          r, off;
         bit          h;
         logic [8:0]  a;
         logic [15:0] d;
         r   = $urandom_range(0, 3);
         off = $urandom_range(0, 7);
         h   = ($urandom_range(0, 7) != 0);
         a   = h ? (BASE + 9'(off)) : {1'b0, 5'($urandom_range(0, 31)), 3'(off)};
         d   = 16'($urandom);
         if (off == 1) d = 16'($urandom_range(0, 12));
         if (off == 4) d = 16'($urandom_range(0, 3));
         check("rand_tick", 16'(tick), 16'(m_en && (m_pcnt == m_presc)));
         check("rand_irq", 16'(irq), 16'(m_match && m_irqen));
         case (r)
            0: begin
               keep = !h;
               rd(a, v);
               keep = 1'b0;
               check("rand_read", v, h ? model_read(off) : 16'h0000);
               model_step(0, h, off, d);
               cyc();
            end
            1: begin
               model_step(1, h, off, d);
               wr(a, d);
            end
            2: begin
               model_step(0, h, off, d);
               cyc();
            end
            default: begin
               keep     = 1'b1;
               mem_cmd  = 2'b11;
               mem_addr = a;
               din      = d;
               #1;
               check("rand_cmd11_no_drive", mem_data, 16'h0000);
               model_step(0, h, off, d);
               cyc();
               mem_cmd  = 2'b00;
               keep     = 1'b0;
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
